// File: rtl/div_seq.sv
// div_seq: sequential sign-magnitude restoring divider.
// A 5-bit sign-magnitude dividend is divided by a 3-bit sign-magnitude divisor.
// Uses a start/busy/done handshake, with four iterations per normal division.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      request a division (sampled only in IDLE)
//   dividend   [4] sign, [3:0] magnitude
//   divisor    [2] sign, [1:0] magnitude
//   quotient   [4] sign, [3:0] magnitude (registered)
//   remainder  [2] sign, [1:0] magnitude (registered)
//   zeroFlag   quotient magnitude is zero (registered)
//   divByZero  divisor magnitude was zero (registered)
//   busy       high while iterating
//   done       one-cycle pulse when results are valid
//
// Optional feature macro: DIV_ZERO_SIGN_CLR_EN
//   When defined, negative-zero quotient/remainder signs are cleared.
module div_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] dividend,
  input  logic [2:0] divisor,
  output logic [4:0] quotient,
  output logic [2:0] remainder,
  output logic       zeroFlag,
  output logic       divByZero,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [1:0] LAST_ITER = 2'd3;

  logic [1:0] state, state_nxt;
  logic [3:0] dq, dq_nxt;     // dividend magnitude, shifted left so bit 3 is the next bit
  logic [1:0] dvs, dvs_nxt;   // divisor magnitude
  logic       qs, qs_nxt;     // quotient sign
  logic       rs, rs_nxt;     // remainder sign
  logic [1:0] r, r_nxt;       // partial remainder (always < 3 between iterations)
  logic [3:0] q, q_nxt;
  logic [1:0] cnt, cnt_nxt;

  logic [4:0] quotient_nxt;
  logic [2:0] remainder_nxt;
  logic       zero_nxt, dbz_nxt, busy_nxt, done_nxt;

  logic [2:0] r_shift;
  logic       ge;
  logic [1:0] r_iter;
  logic [3:0] q_iter;
  logic       qs_fin, rs_fin;

  // One restoring iteration on the current working registers.
  always_comb begin
    r_shift = {r, dq[3]};
    ge      = (r_shift >= {1'b0, dvs});
    r_iter  = ge ? 2'(r_shift - {1'b0, dvs}) : r_shift[1:0];
    q_iter  = {q[2:0], ge};
`ifdef DIV_ZERO_SIGN_CLR_EN
    qs_fin  = qs & (|q_iter);
    rs_fin  = rs & (|r_iter);
`else
    qs_fin  = qs;
    rs_fin  = rs;
`endif
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt     = state;
    dq_nxt        = dq;
    dvs_nxt       = dvs;
    qs_nxt        = qs;
    rs_nxt        = rs;
    r_nxt         = r;
    q_nxt         = q;
    cnt_nxt       = cnt;
    quotient_nxt  = quotient;
    remainder_nxt = remainder;
    zero_nxt      = zeroFlag;
    dbz_nxt       = divByZero;
    busy_nxt      = 1'b0;
    done_nxt      = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          dq_nxt  = dividend[3:0];
          dvs_nxt = divisor[1:0];
          qs_nxt  = dividend[4] ^ divisor[2];
          rs_nxt  = dividend[4];
          r_nxt   = 2'd0;
          q_nxt   = 4'd0;
          cnt_nxt = 2'd0;
          if (divisor[1:0] != 2'd0) begin
            state_nxt = CALC;
            busy_nxt  = 1'b1;
          end else begin
            // Divide by zero skips iteration; sign rule is unaffected by the macro.
            state_nxt     = DONE;
            done_nxt      = 1'b1;
            quotient_nxt  = {dividend[4] ^ divisor[2], 4'b1111};
            remainder_nxt = 3'b000;
            zero_nxt      = 1'b0;
            dbz_nxt       = 1'b1;
          end
        end
      end
      CALC: begin
        r_nxt   = r_iter;
        q_nxt   = q_iter;
        dq_nxt  = {dq[2:0], 1'b0};
        cnt_nxt = cnt + 2'd1;
        if (cnt == LAST_ITER) begin
          state_nxt     = DONE;
          done_nxt      = 1'b1;
          quotient_nxt  = {qs_fin, q_iter};
          remainder_nxt = {rs_fin, r_iter};
          zero_nxt      = (q_iter == 4'd0);
          dbz_nxt       = 1'b0;
        end else begin
          busy_nxt = 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dq        <= 4'd0;
      dvs       <= 2'd0;
      qs        <= 1'b0;
      rs        <= 1'b0;
      r         <= 2'd0;
      q         <= 4'd0;
      cnt       <= 2'd0;
      quotient  <= 5'd0;
      remainder <= 3'd0;
      zeroFlag  <= 1'b0;
      divByZero <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      dq        <= dq_nxt;
      dvs       <= dvs_nxt;
      qs        <= qs_nxt;
      rs        <= rs_nxt;
      r         <= r_nxt;
      q         <= q_nxt;
      cnt       <= cnt_nxt;
      quotient  <= quotient_nxt;
      remainder <= remainder_nxt;
      zeroFlag  <= zero_nxt;
      divByZero <= dbz_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: stimulus pushes expected results, a monitor
// pops and compares on every done pulse and checks that outputs hold between.
module tb_div_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic [4:0] dividend;
  logic [2:0] divisor;
  logic [4:0] quotient;
  logic [2:0] remainder;
  logic       zeroFlag;
  logic       divByZero;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [4:0] q;
    logic [2:0] r;
    logic       zf;
    logic       dz;
    int         busy_cyc;
    string      name;
  } exp_t;

  exp_t sb[$];

  div_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .zeroFlag  (zeroFlag),
    .divByZero (divByZero),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Monitor: compares results on done, checks hold behaviour otherwise.
  int         busy_cnt = 0;
  logic       prev_done = 1'b0;
  logic [9:0] held = 10'd0;

  always @(negedge clk) begin
    if (rst) begin
      busy_cnt  = 0;
      prev_done = 1'b0;
      held      = 10'd0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        if (prev_done) chk("done_single_cycle", 32'(prev_done), 32'd0);
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk({e.name, "_quotient"},  32'(quotient),  32'(e.q));
          chk({e.name, "_remainder"}, 32'(remainder), 32'(e.r));
          chk({e.name, "_zeroFlag"},  32'(zeroFlag),  32'(e.zf));
          chk({e.name, "_divByZero"}, 32'(divByZero), 32'(e.dz));
          chk({e.name, "_busy_cycles"}, 32'(busy_cnt), 32'(e.busy_cyc));
          held = {e.q, e.r, e.zf, e.dz};
        end
        busy_cnt = 0;
      end else begin
        chk("outputs_held", 32'({quotient, remainder, zeroFlag, divByZero}), 32'(held));
      end
      prev_done = done;
    end
  end

  task automatic wait_drain(input string nm);
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk({nm, "_timeout"}, 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic op(input logic [4:0] dd, input logic [2:0] dv,
                    input logic [4:0] eq, input logic [2:0] er,
                    input logic ezf, input logic edz, input int ebusy,
                    input string nm);
    exp_t e;
    e.q = eq; e.r = er; e.zf = ezf; e.dz = edz; e.busy_cyc = ebusy; e.name = nm;
    @(negedge clk);
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    wait_drain(nm);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = 5'd0;
    divisor  = 3'd0;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs", 32'({quotient, remainder, zeroFlag, divByZero, busy, done}), 32'd0);

    op(5'b0_1111, 3'b0_11, 5'b0_0101, 3'b0_00, 1'b0, 1'b0, 4, "p15_p3");
    op(5'b0_1101, 3'b1_10, 5'b1_0110, 3'b0_01, 1'b0, 1'b0, 4, "p13_m2");

    // -7 / +3 with an ignored start (different operands) during CALC.
    e.q = 5'b1_0010; e.r = 3'b1_01; e.zf = 1'b0; e.dz = 1'b0; e.busy_cyc = 4; e.name = "m7_p3";
    @(negedge clk);
    dividend = 5'b1_0111;
    divisor  = 3'b0_11;
    start    = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    dividend = 5'b0_1111;
    divisor  = 3'b0_01;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain("m7_p3");
    idle(8);

    op(5'b0_1001, 3'b1_00, 5'b1_1111, 3'b000, 1'b0, 1'b1, 0, "div_zero");
    op(5'b0_1001, 3'b1_01, 5'b1_1001, 3'b0_00, 1'b0, 1'b0, 4, "p9_m1");
`ifdef DIV_ZERO_SIGN_CLR_EN
    op(5'b1_0000, 3'b0_01, 5'b0_0000, 3'b0_00, 1'b1, 1'b0, 4, "zero_dividend");
    op(5'b1_1111, 3'b1_11, 5'b0_0101, 3'b0_00, 1'b0, 1'b0, 4, "m15_m3");
`else
    op(5'b1_0000, 3'b0_01, 5'b1_0000, 3'b1_00, 1'b1, 1'b0, 4, "zero_dividend");
    op(5'b1_1111, 3'b1_11, 5'b0_0101, 3'b1_00, 1'b0, 1'b0, 4, "m15_m3");
`endif

    // Reset two cycles into CALC: operation aborts with no done.
    @(negedge clk);
    dividend = 5'b0_1111;
    divisor  = 3'b0_01;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idle(2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_outputs", 32'({quotient, remainder, zeroFlag, divByZero, busy, done}), 32'd0);
    idle(8);
    op(5'b0_1000, 3'b0_10, 5'b0_0100, 3'b0_00, 1'b0, 1'b0, 4, "after_abort");

    idle(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
